move_sequencer: RTL and testbench

//  Upstream of the six per-face stepper drivers in the cube robot. Buffers

---
 rtl/move_sequencer.sv | 163 ++++++++++++++++
 tb/tb_move_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Cube-robot move sequencer: FIFO of encoded moves, decode, driver handshake.
// Issues one move at a time and flags illegal codes and stalled drivers.
module move_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int QUARTER_STEPS  = 50,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        move_valid,
  input  logic [4:0]  move_code,
  output logic        move_ready,
  output logic [5:0]  start,
  output logic [7:0]  steps,
  output logic [5:0]  dir,
  input  logic [5:0]  driver_done,
  output logic        busy,
  output logic        bad_code,
  output logic        fault,
  output logic [15:0] moves_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [TW-1:0] TMR_ONE = 1;
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    QSTEPS  = 8'(QUARTER_STEPS);
  localparam logic [7:0]    HSTEPS  = 8'(2 * QUARTER_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]    face_q, face_d;
  logic [7:0]    steps_q, steps_d;
  logic [5:0]    dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          bad_q, bad_d;
  logic          fault_q, fault_d;
  logic [15:0]   cnt_q, cnt_d;

  logic       full;
  logic       empty;
  logic       push;
  logic [4:0] head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = move_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign move_ready = !full;
  assign steps      = steps_q;
  assign dir        = dir_q;
  assign bad_code   = bad_q;
  assign fault      = fault_q;
  assign moves_done = cnt_q;
  assign busy       = !empty || (state_q != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= move_code;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    face_d   = face_q;
    steps_d  = steps_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    bad_d    = bad_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    start    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        face_d   = head[4:2];
        if (head[4:2] > 3'd5) begin
          bad_d   = 1'b1;
          state_d = S_IDLE;
        end else if (head[1:0] == 2'b00) begin
          state_d = S_IDLE;
        end else begin
          steps_d = (head[1:0] == 2'b10) ? HSTEPS : QSTEPS;
          dir_d[head[4:2]] = (head[1:0] == 2'b11);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start[face_q] = 1'b1;
        timer_d = '0;
        state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (driver_done[face_q]) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_IDLE;
        end else if (timer_q == TMR_MAX) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      face_q   <= '0;
      steps_q  <= '0;
      dir_q    <= '0;
      timer_q  <= '0;
      bad_q    <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      face_q   <= face_d;
      steps_q  <= steps_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      bad_q    <= bad_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a simple stepper-driver model.
// Short timeout so the stall path is reachable in a few cycles.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        move_valid = 1'b0;
  logic [4:0]  move_code = '0;
  logic        move_ready;
  logic [5:0]  start;
  logic [7:0]  steps;
  logic [5:0]  dir;
  logic [5:0]  driver_done = '1;
  logic        busy;
  logic        bad_code;
  logic        fault;
  logic [15:0] moves_done;

  int checks = 0;
  int errors = 0;

  int lat = 10;
  bit hang = 1'b0;
  int drv_cnt [6];

  int         ns = 0;
  logic [5:0] rs_start [16];
  logic [7:0] rs_steps [16];
  logic [5:0] rs_dir   [16];

  move_sequencer #(
    .FIFO_DEPTH(8),
    .QUARTER_STEPS(50),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .move_valid(move_valid),
    .move_code(move_code),
    .move_ready(move_ready),
    .start(start),
    .steps(steps),
    .dir(dir),
    .driver_done(driver_done),
    .busy(busy),
    .bad_code(bad_code),
    .fault(fault),
    .moves_done(moves_done)
  );

  always #5 clock = ~clock;

  // driver drops done when it samples start, raises it lat cycles later
  always @(posedge clock) begin
    for (int i = 0; i < 6; i++) begin
      if (start[i]) begin
        driver_done[i] <= 1'b0;
        drv_cnt[i] <= lat;
      end else if (!driver_done[i] && !hang) begin
        if (drv_cnt[i] <= 1) driver_done[i] <= 1'b1;
        else drv_cnt[i] <= drv_cnt[i] - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (start != 6'b0 && ns < 16) begin
      rs_start[ns] = start;
      rs_steps[ns] = steps;
      rs_dir[ns]   = dir;
      ns = ns + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic [4:0] c);
    move_valid = 1'b1;
    move_code  = c;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int acc;
    tick();
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", 32'(move_ready), 32'h1);
    chk("rst_steps", 32'(steps), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_bad", 32'(bad_code), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_moves", 32'(moves_done), 32'h0);

    // single CW quarter turn on face 0, start three cycles after push
    lat = 10;
    push(5'b000_01);
    chk("t1_nostart_idle", 32'(start), 32'h0);
    tick();
    chk("t1_nostart_load", 32'(start), 32'h0);
    tick();
    chk("t1_start", 32'(start), 32'h01);
    chk("t1_steps", 32'(steps), 32'd50);
    chk("t1_dir", 32'(dir), 32'h00);
    chk("t1_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_pulse_end", 32'(start), 32'h0);
    wait_idle("t1_idle");
    chk("t1_moves", 32'(moves_done), 32'd1);
    chk("t1_nstarts", 32'(ns), 32'd1);

    // back-to-back CCW quarter on face 3, then half turn on face 2
    push(5'b011_11);
    push(5'b010_10);
    wait_idle("t2_idle");
    chk("t2_nstarts", 32'(ns), 32'd3);
    chk("t2_s1", 32'(rs_start[1]), 32'h08);
    chk("t2_st1", 32'(rs_steps[1]), 32'd50);
    chk("t2_d1", 32'(rs_dir[1]), 32'h08);
    chk("t2_s2", 32'(rs_start[2]), 32'h04);
    chk("t2_st2", 32'(rs_steps[2]), 32'd100);
    chk("t2_d2", 32'(rs_dir[2]), 32'h08);
    chk("t2_moves", 32'(moves_done), 32'd3);

    // illegal face, nop, then a valid move on face 4
    push(5'b111_01);
    push(5'b001_00);
    push(5'b100_01);
    wait_idle("t4_idle");
    chk("t4_bad", 32'(bad_code), 32'h1);
    chk("t4_nstarts", 32'(ns), 32'd4);
    chk("t4_s", 32'(rs_start[3]), 32'h10);
    chk("t4_moves", 32'(moves_done), 32'd4);
    chk("t4_dir", 32'(dir), 32'h08);

    // done arrives on the final WAIT cycle: done wins over timeout
    lat = 16;
    push(5'b001_01);
    wait_idle("t5a_idle");
    chk("t5a_fault", 32'(fault), 32'h0);
    chk("t5a_moves", 32'(moves_done), 32'd5);
    chk("t5a_bad_sticky", 32'(bad_code), 32'h1);

    // stalled driver: fill FIFO behind it, then timeout
    hang = 1'b1;
    push(5'b000_01);
    tick();
    tick();
    chk("t3_start", 32'(start), 32'h01);
    acc = 0;
    move_valid = 1'b1;
    move_code  = 5'b010_01;
    for (int j = 0; j < 9; j++) begin
      if (move_ready) acc++;
      tick();
    end
    move_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd8);
    chk("t3_ready_full", 32'(move_ready), 32'h0);
    repeat (8) tick();
    chk("t5_fault_pre", 32'(fault), 32'h0);
    tick();
    chk("t5_fault", 32'(fault), 32'h1);
    chk("t5_busy", 32'(busy), 32'h1);
    repeat (20) tick();
    chk("t5_no_more_start", 32'(ns), 32'd6);
    chk("t5_moves", 32'(moves_done), 32'd5);
    chk("t5_still_full", 32'(move_ready), 32'h0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst2_fault", 32'(fault), 32'h0);
    chk("rst2_bad", 32'(bad_code), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_ready", 32'(move_ready), 32'h1);

    // asynchronous reset while waiting on a driver
    push(5'b011_11);
    tick();
    tick();
    chk("t6_start", 32'(start), 32'h08);
    tick();
    tick();
    chk("t6_dir_wait", 32'(dir), 32'h08);
    chk("t6_steps_wait", 32'(steps), 32'd50);
    reset_n = 1'b0;
    #1;
    chk("t6_start0", 32'(start), 32'h0);
    chk("t6_steps0", 32'(steps), 32'h0);
    chk("t6_dir0", 32'(dir), 32'h0);
    chk("t6_moves0", 32'(moves_done), 32'h0);
    chk("t6_busy0", 32'(busy), 32'h0);
    chk("t6_ready", 32'(move_ready), 32'h1);
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
